// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - framed byte-stream loader filling instruction memory
module instruction_loader #(
    parameter int          MEM_BYTES = 128,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  words_loaded
);

    localparam int CW = $clog2(MEM_BYTES) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    words_q, words_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          wr_en_q, wr_en_d;
    logic [63:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic          ready_w;
    logic          xfer;
    logic [31:0]   len_bytes;
    logic [31:0]   last_idx;

    // Ready depends on registered state only, never on in_valid.
    assign ready_w   = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign xfer      = in_valid & ready_w;
    assign len_bytes = {22'd0, in_data, 2'b00};
    assign last_idx  = {22'd0, n_q, 2'b00} - 32'd1;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        words_d   = words_q;
        done_d    = done_q;
        error_d   = error_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = 8'd0;
                    chk_d   = 8'd0;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if ((in_data == 8'd0) || (len_bytes > 32'(MEM_BYTES))) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        n_d     = in_data;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + 64'(cnt_q);
                    wr_data_d = in_data;
                    chk_d     = chk_q ^ in_data;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q[1:0] == 2'b11) begin
                        words_d = words_q + 8'd1;
                    end
                    if (32'(cnt_q) == last_idx) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            n_q       <= 8'd0;
            cnt_q     <= '0;
            chk_q     <= 8'd0;
            words_q   <= 8'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 64'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            words_q   <= words_d;
            done_q    <= done_d;
            error_q   <= error_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready     = ready_w;
    assign busy         = ready_w;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int n_vec = 0;
    int n_err = 0;

    logic [71:0] exp_q[$];
    logic [71:0] mon_e;
    logic [7:0]  prog[0:15];
    logic [7:0]  pay[0:127];
    logic [7:0]  ck;

    instruction_loader #(.MEM_BYTES(128), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%0h data=%0h", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_e) begin
                    n_err++;
                    $display("FAIL write addr/data actual=%0h/%0h required=%0h/%0h",
                             wr_addr, wr_data, mon_e[71:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic frame(input logic [7:0] n, input int nb, input logic [7:0] c,
                         input bit gaps, input int start_at);
        send(n);
        for (int k = 0; k < nb; k++) begin
            exp_q.push_back({64'(k), pay[k]});
            if (k == start_at) start = 1'b1;
            send(pay[k]);
            start = 1'b0;
            if (gaps && (k % 2 == 1)) begin
                repeat (3) begin @(posedge clk); #1; end
            end
        end
        send(c);
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic [7:0] w);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_error"}, 64'(error), 64'(e));
        check({tag, "_words"}, 64'(words_loaded), 64'(w));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic use_prog();
        for (int i = 0; i < 16; i++) pay[i] = prog[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{8'hE5, 8'h03, 8'h1F, 8'h8B, 8'hA4, 8'h00, 8'h40, 8'hF8,
                 8'h86, 8'h00, 8'h04, 8'h8B, 8'hA6, 8'h10, 8'h00, 8'hF8};
        use_prog();

        #1 reset_n = 1'b0;
        #22;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", wr_addr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_error_words", {54'd0, done, error, words_loaded}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // good load
        pulse_start();
        check("len_busy", 64'(busy), 64'd1);
        check("len_ready", 64'(in_ready), 64'd1);
        frame(8'h04, 16, 8'h29, 1'b0, -1);
        status("good", 1'b1, 1'b0, 8'd4);

        // start in DONE, then start pulsed mid-LOAD
        pulse_start();
        check("restart_done_clear", 64'(done), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_words_clear", 64'(words_loaded), 64'd0);
        frame(8'h04, 16, 8'h29, 1'b0, 5);
        status("start_in_load", 1'b1, 1'b0, 8'd4);

        // bad checksum
        pulse_start();
        frame(8'h04, 16, 8'h28, 1'b0, -1);
        status("bad_chk", 1'b0, 1'b1, 8'd4);

        // length limits
        pulse_start();
        send(8'h00);
        status("n_zero", 1'b0, 1'b1, 8'd0);
        pulse_start();
        send(8'h21);
        status("n_33", 1'b0, 1'b1, 8'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("n_33_idle_ready", 64'(in_ready), 64'd0);

        // backpressure
        pulse_start();
        frame(8'h04, 16, 8'h29, 1'b1, -1);
        status("backpressure", 1'b1, 1'b0, 8'd4);

        // full memory: 32 words
        ck = 8'd0;
        for (int i = 0; i < 128; i++) begin
            pay[i] = 8'(i * 7 + 3);
            ck = ck ^ pay[i];
        end
        pulse_start();
        frame(8'h20, 128, ck, 1'b0, -1);
        status("full", 1'b1, 1'b0, 8'h20);

        // reset mid-load
        use_prog();
        pulse_start();
        send(8'h04);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({64'(k), pay[k]});
            send(pay[k]);
        end
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_wr_addr", wr_addr, 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        check("midrst_ready_busy", {62'd0, in_ready, busy}, 64'd0);
        check("midrst_done_error_words", {54'd0, done, error, words_loaded}, 64'd0);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        frame(8'h04, 16, 8'h29, 1'b0, -1);
        status("after_rst", 1'b1, 1'b0, 8'd4);

        repeat (2) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-serial program loader that fills the byte-addressed instruction memory before the CPU fetches from it. It accepts a framed byte stream (word count, payload, XOR checksum) over a valid/ready handshake. It issues one byte write per accepted payload byte, in little-endian order at ascending addresses from BASE_ADDR, which matches the fetch side's byte ordering. It holds `busy` high so the core stays stalled while loading, then reports `done` or `error`.

## Interface
- MEM_BYTES, 128, instruction memory size in bytes; max loadable words = MEM_BYTES/4
- BASE_ADDR, 64'd0, byte address of the first payload byte
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  in_data carries a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready
- wr_en  out  1  one-cycle byte write strobe to instruction memory
- wr_addr  out  64  byte address of the write
- wr_data  out  8  byte to write
- busy  out  1  load in progress (CPU stall)
- done  out  1  last load completed with a good checksum; sticky until next start
- error  out  1  last load rejected; sticky until next start
- words_loaded  out  8  complete 4-byte words written in the current or last load

## Operation
- States: IDLE, LEN, LOAD, CHK, DONE, ERR.
- IDLE/DONE/ERR: in_ready=0, busy=0. On start -> LEN; clear done, error, words_loaded, checksum register and byte counter.
- LEN: in_ready=1. On accept, byte = N (word count).
  - If N==0 or 4*N > MEM_BYTES -> ERR.
  - Else latch N -> LOAD.
- LOAD: in_ready=1. Each accepted byte k (0-based):
  - issue a write of in_data at BASE_ADDR+k;
  - checksum ^= in_data;
  - k increments.
  - words_loaded increments when k%4==3.
  - After byte k = 4N-1 is accepted -> CHK.
- CHK: in_ready=1. Compare the accepted byte with the checksum: equal -> DONE (done=1), else -> ERR (error=1).
- busy=1 exactly in LEN, LOAD and CHK.
- start is ignored in LEN, LOAD and CHK.
- Address arithmetic: 64-bit unsigned. The byte counter is wide enough for MEM_BYTES; the LEN check guarantees writes never exceed BASE_ADDR+MEM_BYTES-1.
- Reset (any time, including mid-LOAD): state IDLE; all outputs 0 (in_ready, wr_en, wr_addr, wr_data, busy, done, error, words_loaded). Already-written memory bytes are not undone.

## Timing
- Throughput: one byte per cycle when in_valid is held high; in_valid gaps stall progress without loss.
- in_ready is a function of registered state only; it does not depend combinationally on in_valid.
- Write latency: wr_en/wr_addr/wr_data are registered and assert the cycle after the accepting edge, for exactly one cycle. wr_en=0 otherwise; wr_addr/wr_data hold their last value.
- LEN is entered on the edge after start; the first in_ready=1 cycle is the next cycle.
- done/error rise the cycle after the checksum byte is accepted, with busy falling on the same edge.
- The final payload write (wr_en) and CHK's in_ready=1 coincide in the same cycle.
- Minimum load time for N words: 1 (start) + 1 + 4N + 1 accepted-byte cycles; done is visible at cycle 4N+3 after start.

## Test plan
- Good load: start, then stream 04, E5 03 1F 8B A4 00 40 F8 86 00 04 8B A6 10 00 F8, 29 back-to-back -> 16 wr_en pulses at addresses 0..15 with those bytes in order; done=1, error=0, words_loaded=4, busy low after.
- Bad checksum: same stream ending with 28 instead of 29 -> 16 writes still occur; error=1, done=0, words_loaded=4.
- Length limits: N=00 -> error=1 with no wr_en. N=21 (33 words) -> error=1 with no wr_en. N=20 (32 words) -> 128 writes, the last at address 127.
- Backpressure: same good stream with in_valid dropped for 3 cycles after every 2nd byte -> identical write sequence, no wr_en during gaps, done=1.
- Reset mid-load: reset_n low after 5 payload bytes -> all outputs 0 asynchronously. A subsequent start plus the good stream writes again from address 0 and ends with done=1.
- Start handling: start pulsed during LOAD -> ignored, load completes normally. start in DONE -> done clears the next cycle, busy=1, new load proceeds.
